// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared width helper for the delay blocks
package delay_line_pkg;

  // Ceiling log2, never below 1, so a select port always has at least one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/delay_line_if.sv
// rtl/delay_line_if.sv - control, data and status bundle of the delay line
interface delay_line_if #(
  parameter int N = 8,
  parameter int D = 4
);
  import delay_line_pkg::*;

  localparam int SW = clog2(D + 1);

  logic          en;
  logic          flush;
  logic [SW-1:0] sel;
  logic [N-1:0]  d;
  logic          vin;
  logic [N-1:0]  q;
  logic          vout;
  logic          primed;

  modport master (
    output en, flush, sel, d, vin,
    input  q, vout, primed
  );

  modport slave (
    input  en, flush, sel, d, vin,
    output q, vout, primed
  );
endinterface

// File: rtl/dly_stage.sv
// rtl/dly_stage.sv - one enabled, flushable register stage of the delay line
module dly_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Flush wins over enable so data presented on a flush edge is discarded.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/delay_line.sv
// rtl/delay_line.sv - selectable-depth data/valid delay line with fill tracking
module delay_line
  import delay_line_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  delay_line_if.slave  bus
);

  localparam int            SW      = clog2(D + 1);
  localparam logic [SW-1:0] SEL_MAX = SW'(D);

  // Each stage carries {valid, data}; the valid bit rides along with its data.
  logic [N:0]    stage_q [D];
  logic [SW-1:0] sel_eff;
  logic [SW-1:0] fill;

  for (genvar i = 0; i < D; i++) begin : g_stage
    logic [N:0] stage_d;
    if (i == 0) begin : g_head
      assign stage_d = {bus.vin, bus.d};
    end else begin : g_link
      assign stage_d = stage_q[i-1];
    end
    dly_stage #(.W(N + 1)) u_stage (
      .clk   (clk),
      .clr_n (clr_n),
      .en    (bus.en),
      .flush (bus.flush),
      .d     (stage_d),
      .q     (stage_q[i])
    );
  end

  // Clamp the requested depth into 1..D; the clamped value drives tap and primed.
  always_comb begin
    sel_eff = bus.sel;
    if (bus.sel == '0) begin
      sel_eff = SW'(1);
    end else if (bus.sel > SEL_MAX) begin
      sel_eff = SEL_MAX;
    end
  end

  // Tap mux: output follows stage[sel_eff-1] with no register, so sel changes act at once.
  always_comb begin
    bus.q    = '0;
    bus.vout = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (sel_eff == SW'(i + 1)) begin
        {bus.vout, bus.q} = stage_q[i];
      end
    end
  end

  // Fill counter counts enabled shifts since reset/flush and saturates at D.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fill <= '0;
    end else if (bus.flush) begin
      fill <= '0;
    end else if (bus.en && (fill != SEL_MAX)) begin
      fill <= fill + SW'(1);
    end
  end

  assign bus.primed = (fill >= sel_eff);

endmodule

// File: tb/tb_delay_line.sv
// tb/tb_delay_line.sv - scoreboard bench for delay_line (N=8, D=4)
module tb_delay_line;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_fail;
  logic [8:0] sb [$];

  delay_line_if #(.N(8), .D(4)) bus ();

  delay_line #(.N(8), .D(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    clr_n     = 1'b0;
    bus.en    = 1'b1;
    bus.flush = 1'b0;
    bus.sel   = 3'd1;
    bus.d     = 8'h05;
    bus.vin   = 1'b1;
    #2;
    n_checks++;
    if ({bus.q, bus.vout, bus.primed} !== 10'h0) begin
      n_fail++; $display("FAIL reset_outputs: got q=%h v=%b p=%b want all 0", bus.q, bus.vout, bus.primed);
    end
    tick();
    n_checks++;
    if ({bus.q, bus.vout, bus.primed} !== 10'h0) begin
      n_fail++; $display("FAIL reset_held_over_edge: got q=%h v=%b p=%b want all 0", bus.q, bus.vout, bus.primed);
    end
    clr_n = 1'b1;
    bus.d = 8'h42;
    tick();
    n_checks++;
    if (bus.q !== 8'h42 || bus.vout !== 1'b1 || bus.primed !== 1'b1) begin
      n_fail++; $display("FAIL first_shift_after_reset: got q=%h v=%b p=%b want 42 1 1", bus.q, bus.vout, bus.primed);
    end
  endtask

  task automatic test_basic();
    logic [7:0] din   [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] exp_q [3] = '{8'h00, 8'h11, 8'h22};
    logic       exp_v [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] item;
    bus.en  = 1'b1;
    bus.vin = 1'b1;
    bus.sel = 3'd2;
    do_flush();
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      bus.d = din[k];
      sb.push_back({1'b1, din[k]});
      tick();
      n_checks++;
      if (bus.q !== exp_q[k] || bus.vout !== exp_v[k] || bus.primed !== exp_v[k]) begin
        n_fail++; $display("FAIL basic_edge%0d: got q=%h v=%b p=%b want q=%h v=%b p=%b",
                           k + 1, bus.q, bus.vout, bus.primed, exp_q[k], exp_v[k], exp_v[k]);
      end
      if (bus.vout === 1'b1) begin
        item = sb.pop_front();
        n_checks++;
        if (bus.q !== item[7:0]) begin
          n_fail++; $display("FAIL basic_sb: got q=%h want %h", bus.q, item[7:0]);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_stall();
    bus.en  = 1'b1;
    bus.vin = 1'b1;
    bus.sel = 3'd2;
    do_flush();
    bus.d = 8'h11;
    tick();
    bus.d = 8'h22;
    tick();
    bus.en = 1'b0;
    bus.d  = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.q !== 8'h11 || bus.primed !== 1'b1 || bus.vout !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold%0d: got q=%h v=%b p=%b want 11 1 1", k, bus.q, bus.vout, bus.primed);
      end
    end
    bus.en = 1'b1;
    tick();
    n_checks++;
    if (bus.q !== 8'h22) begin
      n_fail++; $display("FAIL stall_resume: got q=%h want 22", bus.q);
    end
  endtask

  task automatic test_flush();
    bus.en  = 1'b1;
    bus.vin = 1'b1;
    bus.sel = 3'd4;
    do_flush();
    for (int k = 0; k < 5; k++) begin
      bus.d = 8'hA0 + 8'(k);
      tick();
    end
    n_checks++;
    if (bus.q !== 8'hA1 || bus.vout !== 1'b1 || bus.primed !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: got q=%h v=%b p=%b want a1 1 1", bus.q, bus.vout, bus.primed);
    end
    bus.flush = 1'b1;
    bus.d     = 8'h5A;
    tick();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.q !== 8'h00 || bus.vout !== 1'b0 || bus.primed !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got q=%h v=%b p=%b want 00 0 0", bus.q, bus.vout, bus.primed);
    end
    for (int k = 0; k < 4; k++) begin
      bus.d = 8'h60 + 8'(k);
      tick();
      n_checks++;
      if (bus.vout !== (k == 3) || bus.primed !== (k == 3)) begin
        n_fail++; $display("FAIL flush_refill%0d: got v=%b p=%b want %b", k, bus.vout, bus.primed, (k == 3));
      end
    end
    n_checks++;
    if (bus.q !== 8'h60) begin
      n_fail++; $display("FAIL flush_refill_q: got q=%h want 60", bus.q);
    end
    bus.sel = 3'd1;
    #1;
    n_checks++;
    if (bus.q !== 8'h63 || bus.vout !== 1'b1) begin
      n_fail++; $display("FAIL sel_change_now: got q=%h v=%b want 63 1", bus.q, bus.vout);
    end
  endtask

  task automatic test_clamp();
    logic [8:0] item;
    bus.en  = 1'b1;
    bus.vin = 1'b1;
    bus.sel = 3'd0;
    do_flush();
    bus.d = 8'h31;
    tick();
    n_checks++;
    if (bus.q !== 8'h31 || bus.vout !== 1'b1 || bus.primed !== 1'b1) begin
      n_fail++; $display("FAIL clamp_sel0: got q=%h v=%b p=%b want 31 1 1", bus.q, bus.vout, bus.primed);
    end
    bus.sel = 3'd7;
    #1;
    n_checks++;
    if (bus.primed !== 1'b0) begin
      n_fail++; $display("FAIL clamp_primed_sel7: got p=%b want 0", bus.primed);
    end
    do_flush();
    sb.delete();
    for (int k = 0; k < 6; k++) begin
      bus.d = 8'h41 + 8'(k);
      sb.push_back({1'b1, bus.d});
      tick();
      n_checks++;
      if (bus.vout !== (k >= 3) || bus.primed !== (k >= 3)) begin
        n_fail++; $display("FAIL clamp_sel7_edge%0d: got v=%b p=%b want %b", k + 1, bus.vout, bus.primed, (k >= 3));
      end
      if (k >= 3) begin
        item = sb.pop_front();
        n_checks++;
        if (bus.q !== item[7:0]) begin
          n_fail++; $display("FAIL clamp_sb: got q=%h want %h", bus.q, item[7:0]);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_async_reset();
    bus.en  = 1'b1;
    bus.vin = 1'b1;
    bus.sel = 3'd2;
    do_flush();
    bus.d = 8'hAB;
    tick();
    bus.d = 8'hCD;
    tick();
    n_checks++;
    if (bus.q !== 8'hAB) begin
      n_fail++; $display("FAIL async_pre: got q=%h want ab", bus.q);
    end
    #2;
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.q, bus.vout, bus.primed} !== 10'h0) begin
      n_fail++; $display("FAIL async_clear: got q=%h v=%b p=%b want all 0", bus.q, bus.vout, bus.primed);
    end
    #1;
    clr_n = 1'b1;
    bus.d = 8'h77;
    tick();
    n_checks++;
    if (bus.vout !== 1'b0 || bus.q !== 8'h00) begin
      n_fail++; $display("FAIL async_post1: got q=%h v=%b want 00 0", bus.q, bus.vout);
    end
    bus.d = 8'h88;
    tick();
    n_checks++;
    if (bus.q !== 8'h77 || bus.vout !== 1'b1 || bus.primed !== 1'b1) begin
      n_fail++; $display("FAIL async_post2: got q=%h v=%b p=%b want 77 1 1", bus.q, bus.vout, bus.primed);
    end
  endtask

  task automatic test_bubble();
    logic       vseq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0] item;
    bus.en  = 1'b1;
    bus.sel = 3'd3;
    do_flush();
    sb.delete();
    for (int k = 0; k < 5; k++) begin
      bus.vin = vseq[k];
      bus.d   = 8'h91 + 8'(k);
      sb.push_back({bus.vin, bus.d});
      tick();
      if (k >= 2) begin
        item = sb.pop_front();
        n_checks++;
        if ({bus.vout, bus.q} !== item) begin
          n_fail++; $display("FAIL bubble_edge%0d: got v=%b q=%h want v=%b q=%h", k + 1, bus.vout, bus.q, item[8], item[7:0]);
        end
      end else begin
        n_checks++;
        if (bus.vout !== 1'b0) begin
          n_fail++; $display("FAIL bubble_fill%0d: got v=%b want 0", k + 1, bus.vout);
        end
      end
    end
    sb.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_clamp();
    test_async_reset();
    test_bubble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter N, default 8: data width in bits; the block SHALL support N >= 1.
REQ-002 Parameter D, default 4: maximum delay depth in register stages; the block SHALL support D >= 1.
REQ-003 Derived constant SW = clog2(D+1): width of the delay-select port.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 clr_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  advance enable; 1 = shift one stage this cycle, 0 = hold every stage.
REQ-007 flush  input  1  synchronous clear of the pipeline contents.
REQ-008 sel  input  SW  delay select, in stages; legal range 1..D.
REQ-009 d  input  N  data in.
REQ-010 vin  input  1  valid qualifier for d.
REQ-011 q  output  N  delayed data.
REQ-012 vout  output  1  valid qualifier for q.
REQ-013 primed  output  1  1 = at least sel enabled shifts have occurred since the last reset or flush.

Function
REQ-014 The block SHALL hold D stages, stage[0..D-1], each with N data bits and 1 valid bit.
REQ-015 On a clock edge with en=1 and flush=0, the block SHALL load stage[0] from d/vin and load stage[i] from stage[i-1] for i = 1..D-1.
REQ-016 On a clock edge with en=0 and flush=0, every stage, the fill counter, q and vout SHALL hold their values.
REQ-017 The block SHALL drive q and vout combinationally from stage[s-1], where s is the effective select.
REQ-018 With en held at 1, d/vin presented before edge k SHALL appear on q/vout after edge k+s-1, so the latency is s enabled cycles.
REQ-019 The effective select SHALL be s = 1 when sel = 0, s = D when sel > D, and s = sel otherwise.
REQ-020 A change of sel SHALL take effect in the same cycle, with no flush and no drain; stage contents SHALL stay unaffected, so data may repeat or be skipped.
REQ-021 On an edge with flush=1, every valid bit and every data bit SHALL clear to 0 and the fill counter SHALL clear to 0, regardless of en.
REQ-022 When flush and en are both 1, flush SHALL take priority and d/vin SHALL be discarded.
REQ-023 A fill counter of SW bits SHALL increment on each enabled, non-flush edge and SHALL saturate at D without wrapping.
REQ-024 primed SHALL equal 1 exactly when the fill counter is >= s; it is combinational, so it reflects a sel change immediately.
REQ-025 vout SHALL depend only on the valid bits shifted through the stages; vout SHALL be independent of primed.
REQ-026 When D=1, the block SHALL behave as a single enabled, flushable register, and sel SHALL be ignored beyond clamping.

Reset
REQ-027 While clr_n=0, all stages, the fill counter, q, vout and primed SHALL be 0 asynchronously, independent of clk.
REQ-028 Reset deassertion SHALL be sampled as synchronous to clk.
REQ-029 The first possible shift after reset SHALL occur on the first rising edge with clr_n=1 and en=1.
REQ-030 A reset asserted mid-stream SHALL drop all in-flight data; there is no recovery of contents.

Structure
REQ-031 The SW computation, as a clog2 function, SHALL live in the shared package or header common to the tarea delay blocks.
REQ-032 One sub-module, dly_stage, SHALL implement a single N+1-bit register with clr_n, en and flush.
REQ-033 delay_line SHALL instantiate D copies of dly_stage through a generate loop.
REQ-034 The tap mux, the fill counter and the primed compare SHALL reside in delay_line.

Verification
REQ-035 Bench settings are N=8, D=4, sel=2, en=1, vin=1, and d=0x11, 0x22, 0x33 on successive cycles; after edges 1..3, q SHALL read 0x00, 0x11, 0x22; vout SHALL be 1 from edge 2; primed SHALL be 1 from edge 2.
REQ-036 Stall: start from REQ-035 after edge 2 (q=0x11), drive en=0 for 3 cycles with d=0xFF; q SHALL stay 0x11, primed SHALL stay 1, and 0xFF SHALL never appear on q.
REQ-037 Flush priority: stages full with vin=1 and sel=4; assert flush=1 and en=1 for one cycle; then vout=0, q=0x00 and primed=0, and vout SHALL return after 4 further enabled edges.
REQ-038 Select clamp: drive sel=0, then sel=7; the latency SHALL be 1 cycle for sel=0 and 4 cycles for sel=7; primed SHALL track the clamped value.
REQ-039 Async reset: pulse clr_n low for 2 ns between clock edges while q=0xAB; q, vout and primed SHALL go to 0 immediately, and the next d SHALL appear after sel edges.
REQ-040 Bubble tracking: sel=3 with vin sequence 1,0,1; vout SHALL show 1,0,1 three edges later, and q on the bubble SHALL carry the data captured with it.
